// File: rtl/div.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, valid/ready on both sides, one op in flight.
//
// state | meaning
// IDLE  | ready for a new operation, in_ready=1
// CALC  | 2N restoring steps in progress, inputs ignored
// DONE  | result presented, held until out_ready
module div #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   prem;
  logic [2*N-1:0] shreg;
  logic [N-1:0]   dsr;
  logic [CW-1:0]  count;

  logic [N:0]     shifted;
  logic [N-1:0]   diff;
  logic           q_bit;
  logic [N-1:0]   prem_nx;
  logic [2*N-1:0] shreg_nx;
  logic           accept;
  logic           last_step;

  // One restoring step: shift in the dividend MSB, trial-subtract the divisor.
  // The partial remainder is always below the divisor, so N bits of storage
  // suffice; only the shifted trial value needs the extra bit.
  always_comb begin
    shifted  = {prem, shreg[2*N-1]};
    diff     = shifted[N-1:0] - dsr;
    q_bit    = (shifted >= {1'b0, dsr});
    prem_nx  = q_bit ? diff : shifted[N-1:0];
    shreg_nx = {shreg[2*N-2:0], q_bit};
  end

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == CALC) && (count == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; handshake outputs depend only on state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (count == CW'(1)) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract iteration, result registers.
  // Result registers only change when a new result is loaded, so they
  // persist through IDLE and the next CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prem        <= '0;
      shreg       <= '0;
      dsr         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dsr   <= divisor;
      shreg <= dividend;
      prem  <= '0;
      count <= CW'(2*N);
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend[N-1:0];
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (state == CALC) begin
      prem  <= prem_nx;
      shreg <= shreg_nx;
      count <= count - CW'(1);
      if (last_step) begin
        quotient  <= shreg_nx;
        remainder <= prem_nx;
      end
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div (N=4): directed cases plus a random sweep,
// checked against a plain-arithmetic division model.
module tb_div;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  div #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*N-1:0] exp_q = '0;
  logic [N-1:0]   exp_r = '0;
  logic           exp_z = 1'b0;
  logic           exp_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer division, all-ones/low-bits on zero divisor.
  task automatic set_model(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    if (dv == '0) begin
      exp_q = '1;
      exp_r = dd[N-1:0];
      exp_z = 1'b1;
    end else begin
      exp_q = dd / dv;
      exp_r = dd % dv;
      exp_z = 1'b0;
    end
    exp_live = 1'b1;
  endtask

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("out_valid_expected", exp_live, 1);
      check("quotient", quotient, exp_q);
      check("remainder", remainder, exp_r);
      check("div_by_zero", div_by_zero, exp_z);
      check("in_ready_low_in_done", in_ready, 0);
    end
  end

  time t_accept;

  // Presents an operation at a negedge; returns at the negedge after accept.
  task automatic start(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    dividend = dd;
    divisor  = dv;
    set_model(dd, dv);
    in_valid = 1'b1;
    @(posedge clk);
    t_accept = $time;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_result(input logic [N-1:0] dv);
    int edges;
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("result_timeout", out_valid, 1);
    check("latency_edges", edges, (dv == '0) ? 1 : 2*N+1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_live  = 1'b0;
    check("in_ready_after_hs", in_ready, 1);
    check("out_valid_after_hs", out_valid, 0);
  endtask

  task automatic op(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
    start(dd, dv);
    wait_result(dv);
    handshake();
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
  endtask

  initial begin
    time t_prev;
    logic [2*N-1:0] dd;
    logic [N-1:0]   dv;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // 200/7 with 5 cycles of backpressure; in_valid during DONE must be ignored.
    start(8'd200, 4'd7);
    wait_result(4'd7);
    check("lit_200_7_q", quotient, 28);
    check("lit_200_7_r", remainder, 4);
    check("lit_200_7_z", div_by_zero, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 8'd13;
      divisor  = 4'd15;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 28);
      check("bp_remainder", remainder, 4);
    end
    in_valid = 1'b0;
    handshake();
    check("persist_quotient", quotient, 28);
    check("persist_remainder", remainder, 4);

    op(8'd255, 4'd1);
    check("lit_255_1_q", quotient, 255);
    check("lit_255_1_r", remainder, 0);
    op(8'd13, 4'd15);
    check("lit_13_15_q", quotient, 0);
    check("lit_13_15_r", remainder, 13);
    op(8'd100, 4'd0);
    check("lit_100_0_q", quotient, 8'hFF);
    check("lit_100_0_r", remainder, 4'h4);
    check("lit_100_0_z", div_by_zero, 1);

    // Reset sampled on edge T0+3 of a 200/7 divide.
    start(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b0;
    exp_live = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values();
    op(8'd120, 4'd11);
    check("lit_120_11_q", quotient, 10);
    check("lit_120_11_r", remainder, 10);

    // Random sweep, out_ready held high, nonzero divisors.
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      dd = 8'($urandom_range(255, 0));
      dv = 4'($urandom_range(15, 1));
      start(dd, dv);
      if (i > 0) check("period_cycles", 32'((t_accept - t_prev) / 10), 2*N+2);
      t_prev = t_accept;
      wait_result(dv);
      check("inv_exact", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
      check("inv_rem_lt_div", (remainder < dv), 1);
      @(negedge clk);
      exp_live = 1'b0;
    end
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
